instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the 16-entry program ROM. Owns the program counter and drives the ROM address.
//  Latches each fetched word into an instruction register and hands it to decode over a valid/ready handshake.
//  Resolves jmp (always) and br (when condition flag set) by redirecting the PC.
//  Sits between program ROM and the decode/execute datapath.
// PARAMETERS
//  ADDR_W    4       ROM address width; PC wraps modulo 2**ADDR_W
//  INST_W    16      instruction width
//  RESET_PC  0       PC loaded at reset and on every start
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       1-cycle pulse; begins fetching at RESET_PC from IDLE or HALTED
//  rom_addr     out  ADDR_W  ROM address (= pc, combinational)
//  rom_inst     in   INST_W  ROM data; combinational from rom_addr
//  ir           out  INST_W  instruction register
//  ir_pc        out  ADDR_W  address ir was fetched from
//  ir_valid     out  1       ir holds an instruction for decode
//  ir_ready     in   1       decode accepts ir this cycle
//  br_cond      in   1       branch condition from execute (1 = take br); sampled at handshake
//  halt         in   1       stop after current instruction; sampled at handshake
//  halted       out  1       controller in HALTED
//  retired_cnt  out  16      instructions accepted by decode (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0, retired_cnt=0.
//  FSM states IDLE, FETCH, ISSUE, HALTED:
//   IDLE:   ir_valid=0; start -> FETCH, pc<=RESET_PC.
//   FETCH:  ir<=rom_inst, ir_pc<=pc; -> ISSUE. One cycle, unconditional.
//   ISSUE:  ir_valid=1; ir, ir_pc stable while ir_valid && !ir_ready.
//           Handshake (ir_valid && ir_ready) retires ir and computes next pc:
//            ir[15:12]==4'b1000 (jmp)           -> pc<=ir[11:8]
//            ir[15:12]==4'b1100 (br) && br_cond -> pc<=ir[11:8]
//            otherwise                          -> pc<=ir_pc+1, wrapping 15->0
//           then: halt=1 -> HALTED; else -> FETCH.
//   HALTED: halted=1, ir_valid=0; start -> FETCH, pc<=RESET_PC.
//  Throughput: one instruction per 2 cycles when ir_ready is held high; ir_valid rises 2 cycles after start.
//  Target field ir[11:8] is truncated/zero-extended to ADDR_W.
//  Boundaries:
//   - start in FETCH/ISSUE is ignored.
//   - halt outside handshake is ignored.
//   - br_cond is ignored for non-br opcodes.
//   - jmp/br to own address loops legally.
//   - ir_ready without ir_valid has no effect.
//   - rst_n low mid-ISSUE drops ir_valid immediately; an unretired instruction is lost.
//   - Unwritten ROM entries (X/0) are treated as ordinary non-branch opcodes.
// CONFIGURATION
//  INSTR_COUNT_EN defined:
//   - retired_cnt increments by 1 on each handshake.
//   - Saturates at 16'hFFFF.
//   - Cleared only by reset; start does not clear it.
//  INSTR_COUNT_EN undefined:
//   - retired_cnt tied to 16'h0000; no counter flops.
// TESTING
//  T1 reset: rst_n=0 mid-ISSUE -> ir_valid=0, halted=0, rom_addr=0, retired_cnt=0 asynchronously.
//  T2 linear: ROM 0..3 = non-branch, start, ir_ready=1 -> ir_pc sequence 0,1,2,3; ir_valid high every 2nd cycle.
//  T3 jmp: mem[7]=16'h8300 (jmp 3) -> ir_pc after 7 is 3.
//  T4 br: mem[4]=16'hCA00, br_cond=1 -> next ir_pc 10; br_cond=0 -> next ir_pc 5.
//  T5 backpressure/wrap: mem[15] non-branch, hold ir_ready=0 for 5 cycles -> ir/ir_pc stable at 15; release -> next ir_pc 0.
//  T6 halt/restart: halt=1 at handshake of pc 2 -> halted=1, ir_valid=0; start -> ir_pc 0;
//     with INSTR_COUNT_EN retired_cnt=3 after pcs 0,1,2; without it, retired_cnt stays 0.

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus of instr_fetch_ctrl: ROM address/data plus the decode handshake.
// The master modport is the fetch controller; the slave modport is the ROM/decode side.
`timescale 1ns/1ps
interface instr_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned INST_W = 16
);
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic [INST_W-1:0] ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic              br_cond;
  logic              halt;

  modport master (
    output rom_addr, ir, ir_pc, ir_valid,
    input  rom_inst, ir_ready, br_cond, halt
  );

  modport slave (
    input  rom_addr, ir, ir_pc, ir_valid,
    output rom_inst, ir_ready, br_cond, halt
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, latches ROM words into IR and issues them to decode.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
`timescale 1ns/1ps
module instr_fetch_ctrl #(
  parameter int unsigned      ADDR_W   = 4,
  parameter int unsigned      INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  instr_fetch_ctrl_if.master  bus,
  output logic                halted,
  output logic [15:0]         retired_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_JMP = 4'b1000;
  localparam logic [3:0] OP_BR  = 4'b1100;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;

  logic                handshake;
  logic [3:0]          opcode;
  logic                take;
  logic [ADDR_W-1:0]   target;
  logic [ADDR_W-1:0]   seq_pc;

  // ir_valid is decoded straight from the state so reset drops it asynchronously.
  assign handshake    = (state_q == S_ISSUE) && bus.ir_ready;
  assign opcode       = ir_q[15:12];
  assign target       = ADDR_W'(ir_q[11:8]);
  assign seq_pc       = ir_pc_q + ADDR_W'(1);
  assign take         = (opcode == OP_JMP) || ((opcode == OP_BR) && bus.br_cond);

  assign bus.rom_addr = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = (state_q == S_ISSUE);
  assign halted       = (state_q == S_HALTED);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
        end
      end
      S_FETCH: begin
        ir_d    = bus.rom_inst;
        ir_pc_d = pc_q;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (handshake) begin
          pc_d    = take ? target : seq_pc;
          state_d = bus.halt ? S_HALTED : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ir_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
    end
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of accepted instructions; only reset clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (handshake && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_cnt = cnt_q;
`else
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: ROM model, handshake scoreboard, branch decode table.
`timescale 1ns/1ps
module tb_instr_fetch_ctrl;

  typedef struct packed {
    logic [15:0] ir;
    logic [3:0]  pc;
  } exp_t;

  typedef struct {
    logic [15:0] inst;
    logic        bc;
    logic [3:0]  exp_pc;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halted;
  logic [15:0] retired_cnt;
  logic [15:0] mem [16];

  int unsigned n_cmp;
  int unsigned n_err;
  exp_t        sb [$];
  vec_t        vecs [12];

  instr_fetch_ctrl_if #(.ADDR_W(4), .INST_W(16)) bus ();

  instr_fetch_ctrl #(.ADDR_W(4), .INST_W(16), .RESET_PC(4'd0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .halted      (halted),
    .retired_cnt (retired_cnt)
  );

  assign bus.rom_inst = mem[bus.rom_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_linear();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0A00 | 16'(i);
  endtask

  task automatic push(input logic [3:0] pc);
    sb.push_back('{ir: mem[pc], pc: pc});
  endtask

  task automatic wait_valid(output logic ok);
    for (int i = 0; i < 16 && !bus.ir_valid; i++) tick();
    ok = bus.ir_valid;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_valid: got ir_valid=0 expected 1 within 16 cycles");
    end
  endtask

  // Handshake one instruction; the scoreboard entry is checked while ir_valid&&ir_ready.
  task automatic issue_one(input logic bc, input logic h);
    logic ok;
    exp_t e;
    wait_valid(ok);
    if (ok) begin
      bus.ir_ready = 1'b1;
      bus.br_cond  = bc;
      bus.halt     = h;
      @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_empty: got handshake at pc %0d expected none", bus.ir_pc);
      end else begin
        e = sb.pop_front();
        check("sb_ir", 32'(bus.ir), 32'(e.ir));
        check("sb_pc", 32'(bus.ir_pc), 32'(e.pc));
      end
      tick();
      bus.ir_ready = 1'b0;
      bus.br_cond  = 1'b0;
      bus.halt     = 1'b0;
    end
  endtask

  initial begin
    logic ok;
    logic [15:0] cnt_exp;
    n_cmp = 0;
    n_err = 0;
    vecs[0]  = '{16'h8300, 1'b0, 4'd3};
    vecs[1]  = '{16'h8300, 1'b1, 4'd3};
    vecs[2]  = '{16'hCA00, 1'b1, 4'd10};
    vecs[3]  = '{16'hCA00, 1'b0, 4'd1};
    vecs[4]  = '{16'h4A00, 1'b1, 4'd1};
    vecs[5]  = '{16'h9500, 1'b1, 4'd1};
    vecs[6]  = '{16'hD500, 1'b1, 4'd1};
    vecs[7]  = '{16'h8000, 1'b0, 4'd0};
    vecs[8]  = '{16'hC000, 1'b1, 4'd0};
    vecs[9]  = '{16'hCF00, 1'b1, 4'd15};
    vecs[10] = '{16'hFFFF, 1'b1, 4'd1};
    vecs[11] = '{16'h0000, 1'b1, 4'd1};

    rst_n = 1'b0;
    start = 1'b0;
    bus.ir_ready = 1'b0;
    bus.br_cond  = 1'b0;
    bus.halt     = 1'b0;
    load_linear();
    #12;
    check("rst_ir_valid", 32'(bus.ir_valid), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_rom_addr", 32'(bus.rom_addr), 0);
    check("rst_ir", 32'(bus.ir), 0);
    check("rst_cnt", 32'(retired_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // T2 linear with ready held high: valid every other cycle
    start_pulse();
    check("t2_lat_fetch", 32'(bus.ir_valid), 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t2_valid_hi", 32'(bus.ir_valid), 1);
      push(4'(k));
      bus.ir_ready = 1'b1;
      bus.halt     = (k == 3);
      @(negedge clk);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("t2_ir", 32'(bus.ir), 32'(e.ir));
        check("t2_pc", 32'(bus.ir_pc), 32'(e.pc));
      end
      tick();
      bus.halt = 1'b0;
      check("t2_valid_lo", 32'(bus.ir_valid), 0);
      if (k < 3) tick();
    end
    bus.ir_ready = 1'b0;
    check("t2_halted", 32'(halted), 1);

    // T3 jmp from 7 to 3
    mem[7] = 16'h8300;
    start_pulse();
    for (int k = 0; k < 8; k++) push(4'(k));
    push(4'd3);
    for (int k = 0; k < 8; k++) issue_one(1'b0, 1'b0);
    issue_one(1'b0, 1'b1);
    check("t3_halted", 32'(halted), 1);
    load_linear();

    // T1 reset mid-ISSUE loses the pending instruction
    start_pulse();
    for (int k = 0; k < 3; k++) push(4'(k));
    for (int k = 0; k < 3; k++) issue_one(1'b0, 1'b0);
    wait_valid(ok);
    check("t1_pre_pc", 32'(bus.ir_pc), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_ir_valid", 32'(bus.ir_valid), 0);
    check("t1_halted", 32'(halted), 0);
    check("t1_rom_addr", 32'(bus.rom_addr), 0);
    check("t1_ir_pc", 32'(bus.ir_pc), 0);
    check("t1_cnt", 32'(retired_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t1_idle_valid", 32'(bus.ir_valid), 0);

    // Branch decode table: instruction at address 0, next fetched pc checked
    foreach (vecs[v]) begin
      mem[0] = vecs[v].inst;
      start_pulse();
      push(4'd0);
      push(vecs[v].exp_pc);
      issue_one(vecs[v].bc, 1'b0);
      issue_one(1'b0, 1'b1);
      check("tbl_halted", 32'(halted), 1);
    end
    load_linear();

    // T4 br at address 4, taken then not taken
    mem[4] = 16'hCA00;
    for (int r = 0; r < 2; r++) begin
      start_pulse();
      for (int k = 0; k < 5; k++) push(4'(k));
      push(r == 0 ? 4'd10 : 4'd5);
      for (int k = 0; k < 4; k++) issue_one(1'b1, 1'b0);
      issue_one(r == 0, 1'b0);
      issue_one(1'b0, 1'b1);
    end
    load_linear();

    // T5 backpressure at 15, ignored start/halt, wrap to 0
    mem[0] = 16'h8F00;
    start_pulse();
    push(4'd0);
    issue_one(1'b0, 1'b0);
    wait_valid(ok);
    for (int c = 0; c < 5; c++) begin
      start    = (c == 1);
      bus.halt = (c == 2);
      tick();
      start    = 1'b0;
      bus.halt = 1'b0;
      check("t5_valid", 32'(bus.ir_valid), 1);
      check("t5_pc", 32'(bus.ir_pc), 15);
      check("t5_ir", 32'(bus.ir), 32'(mem[15]));
    end
    check("t5_not_halted", 32'(halted), 0);
    push(4'd15);
    push(4'd0);
    issue_one(1'b0, 1'b0);
    issue_one(1'b0, 1'b1);
    load_linear();

    // T6 halt/restart and retired count
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start_pulse();
    for (int k = 0; k < 3; k++) push(4'(k));
    issue_one(1'b0, 1'b0);
    issue_one(1'b0, 1'b0);
    issue_one(1'b0, 1'b1);
    check("t6_halted", 32'(halted), 1);
    check("t6_valid", 32'(bus.ir_valid), 0);
`ifdef INSTR_COUNT_EN
    cnt_exp = 16'd3;
`else
    cnt_exp = 16'd0;
`endif
    check("t6_cnt3", 32'(retired_cnt), 32'(cnt_exp));
    start_pulse();
    check("t6_restart_unhalt", 32'(halted), 0);
    push(4'd0);
    issue_one(1'b0, 1'b1);
`ifdef INSTR_COUNT_EN
    cnt_exp = 16'd4;
`else
    cnt_exp = 16'd0;
`endif
    check("t6_cnt4", 32'(retired_cnt), 32'(cnt_exp));

    check("sb_leftover", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
